wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Clk  in  1  sole clock; all state updates on posedge Clk.
REQ-002 Reset  in  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-003 AluValid, AluReg, AluData  in  1/5/64  ALU writeback request: valid, destination register, result.
REQ-004 MemValid, MemReg, MemData  in  1/5/64  load writeback request: valid, destination register, load data.
REQ-005 Stall  out  1  combinational; requests not accepted this cycle, sources must hold.
REQ-006 w, c, DataC  out  1/5/64  register-bank write port: enable, write address, write data.
REQ-007 a, b  in  5/5  register-bank read addresses, also driven to the bank.
REQ-008 RegDataA, RegDataB  in  64/64  raw read data returned by the bank.
REQ-009 DataA, DataB  out  64/64  forwarded read data for the pipeline.
REQ-010 Count  out  3  number of queued entries, 0..4.
REQ-011 Full, Empty  out  1/1  Count==4 and Count==0 respectively.

Function
REQ-012 The queue SHALL be a 4-entry circular FIFO of {reg[4:0], data[63:0]}, with 2-bit head and tail pointers that wrap from 3 to 0.
REQ-013 Drain: when Empty=0, the block SHALL drive w=1, c=head.reg, DataC=head.data combinationally and pop the head at the clock edge; when Empty=1, w=0, c=0, DataC=0.
REQ-014 Exactly one entry SHALL be popped per cycle while non-empty, with no back-pressure from the bank.
REQ-015 The number of requests, N, SHALL be the count of valid requests with reg!=31; a valid request with reg==31 (XZR) SHALL be accepted and discarded without being enqueued.
REQ-016 Free slots SHALL be computed as F = 4 - Count + (Empty ? 0 : 1), so that a pop in the same cycle frees a slot.
REQ-017 Stall SHALL be 1 iff N > F, and SHALL be 0 whenever N==0.
REQ-018 Acceptance SHALL be all-or-none: if Stall=1, neither request is enqueued.
REQ-019 If both requests are enqueued in the same cycle, Mem SHALL be written at tail and Alu at tail+1, so Mem is older.
REQ-020 At each edge, Count_next SHALL equal Count + enqueued - popped.
REQ-021 Simultaneous push and pop at Count==4 SHALL be legal: with N==1 the push is accepted, and with N==2 the cycle stalls.
REQ-022 Forwarding: DataA SHALL be 0 if a==31; otherwise it SHALL be the data of the youngest queued entry (head included) with reg==a; otherwise it SHALL be RegDataA. DataB SHALL follow the same rule using b and RegDataB.
REQ-023 Same-cycle incoming requests SHALL NOT be forwarded; only entries already queued are forwarded.
REQ-024 Duplicate destinations in the queue SHALL be legal; they drain in order, and the last write wins in the bank.
REQ-025 Data SHALL pass unmodified at 64 bits; entry data SHALL NOT be reset.

Reset
REQ-026 On Reset=1 at an edge: head=tail=0, Count=0, Empty=1, Full=0; the following cycle w=0, c=0, DataC=0.
REQ-027 Reset SHALL take priority over a simultaneous push or pop; pending entries are dropped and not written.
REQ-028 While Reset=1, Stall SHALL be 0 and inputs SHALL be ignored.

Verification
REQ-029 Scenario: single push, AluValid=1, AluReg=5, AluData=0x1234 with queue empty -> next cycle w=1, c=5, DataC=0x1234, Count=1; the cycle after, Empty=1.
REQ-030 Scenario: dual push, Mem(reg 3, 0xAA) plus Alu(reg 4, 0xBB) with queue empty -> bank writes (3,0xAA) then (4,0xBB) on consecutive cycles.
REQ-031 Scenario: fill to Count=4, then present a dual push -> Stall=1 and Count stays 4; present a single push -> accepted, Count stays 4 (pop plus push), and the pointers wrap correctly.
REQ-032 Scenario: queue holds (7,0x11) then (7,0x22), a=7, RegDataA=0x99 -> DataA=0x22; after both drain, DataA=RegDataA.
REQ-033 Scenario: AluValid=1, AluReg=31 -> Stall=0, Count unchanged, w never asserted for it; a=31 -> DataA=0.
REQ-034 Scenario: Reset asserted with Count=3 -> next cycle Count=0, w=0, and no queued entries are ever written.

Source files
------------

// File: rtl/wb_queue_if.sv
// Writeback queue bus: ALU/load writeback requests, register-bank write and read ports,
// and queue status. The pipeline side uses master; the queue itself uses slave.
interface wb_queue_if;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [63:0] AluData;
  logic        MemValid;
  logic [4:0]  MemReg;
  logic [63:0] MemData;
  logic        Stall;
  logic        w;
  logic [4:0]  c;
  logic [63:0] DataC;
  logic [4:0]  a;
  logic [4:0]  b;
  logic [63:0] RegDataA;
  logic [63:0] RegDataB;
  logic [63:0] DataA;
  logic [63:0] DataB;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;

  modport master (
    output AluValid, AluReg, AluData, MemValid, MemReg, MemData,
    output a, b, RegDataA, RegDataB,
    input  Stall, w, c, DataC, DataA, DataB, Count, Full, Empty
  );

  modport slave (
    input  AluValid, AluReg, AluData, MemValid, MemReg, MemData,
    input  a, b, RegDataA, RegDataB,
    output Stall, w, c, DataC, DataA, DataB, Count, Full, Empty
  );
endinterface

// File: rtl/wb_queue.sv
// 4-entry writeback queue between ALU/load results and the register bank, draining one
// entry per cycle and forwarding queued (not yet written) results to register reads.
module wb_queue (
  input  logic       Clk,
  input  logic       Reset,
  wb_queue_if.slave  bus
);

  logic [4:0]  qreg  [4];
  logic [63:0] qdata [4];
  logic [1:0]  head, tail;
  logic [2:0]  cnt;

  logic        alu_req, mem_req;
  logic [1:0]  nreq, nenq;
  logic [2:0]  nfree;
  logic        empty, pop, accept;
  logic [1:0]  alu_slot;

  assign alu_req = bus.AluValid && (bus.AluReg != 5'd31);
  assign mem_req = bus.MemValid && (bus.MemReg != 5'd31);
  assign nreq    = {1'b0, alu_req} + {1'b0, mem_req};

  assign empty = (cnt == 3'd0);
  assign pop   = !empty;

  // A pop in the same cycle frees a slot, so a full queue still takes one new entry.
  assign nfree = 3'd4 - cnt + {2'b00, pop};

  assign bus.Stall = !Reset && ({1'b0, nreq} > nfree);
  assign accept    = !Reset && !bus.Stall;
  assign nenq      = accept ? nreq : 2'd0;
  // Mem is older than Alu when both arrive together.
  assign alu_slot  = tail + {1'b0, mem_req};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop) head <= head + 2'd1;
      tail <= tail + nenq;
      cnt  <= cnt + {1'b0, nenq} - {2'b00, pop};
    end
  end

  always_ff @(posedge Clk) begin
    if (accept && mem_req) begin
      qreg[tail]  <= bus.MemReg;
      qdata[tail] <= bus.MemData;
    end
    if (accept && alu_req) begin
      qreg[alu_slot]  <= bus.AluReg;
      qdata[alu_slot] <= bus.AluData;
    end
  end

  assign bus.w     = pop;
  assign bus.c     = pop ? qreg[head]  : '0;
  assign bus.DataC = pop ? qdata[head] : '0;
  assign bus.Count = cnt;
  assign bus.Full  = (cnt == 3'd4);
  assign bus.Empty = empty;

  // Walk oldest to youngest so the youngest matching entry wins.
  function automatic logic [63:0] fwd(input logic [4:0] addr, input logic [63:0] raw);
    logic [63:0] res;
    logic [1:0]  idx;
    res = raw;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = head + 2'(i);
      if ((3'(i) < cnt) && (qreg[idx] == addr)) res = qdata[idx];
    end
    if (addr == 5'd31) res = '0;
    return res;
  endfunction

  assign bus.DataA = fwd(bus.a, bus.RegDataA);
  assign bus.DataB = fwd(bus.b, bus.RegDataB);

endmodule

// File: tb/tb_wb_queue.sv
// Directed and randomised checks of wb_queue against a queue-based scoreboard of
// pending bank writes.
module tb_wb_queue;

  typedef struct packed {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t sbq[$];

  wb_queue_if bus ();

  wb_queue dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nreq_model();
    int n = 0;
    if (bus.AluValid && bus.AluReg != 5'd31) n++;
    if (bus.MemValid && bus.MemReg != 5'd31) n++;
    return n;
  endfunction

  function automatic logic stall_model();
    int f;
    if (rst) return 1'b0;
    f = 4 - sbq.size() + ((sbq.size() > 0) ? 1 : 0);
    return (nreq_model() > f);
  endfunction

  function automatic logic [63:0] fwd_model(input logic [4:0] addr, input logic [63:0] raw);
    if (addr == 5'd31) return '0;
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].r == addr) return sbq[i].d;
    return raw;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [63:0] md);
    bus.AluValid = av; bus.AluReg = ar; bus.AluData = ad;
    bus.MemValid = mv; bus.MemReg = mr; bus.MemData = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Check all outputs mid-cycle, then retire/enqueue in the scoreboard at the edge.
  task automatic tick();
    logic st;
    ent_t e;
    @(negedge clk);
    st = stall_model();
    chk("stall", 64'(bus.Stall), 64'(st));
    chk("count", 64'(bus.Count), 64'(sbq.size()));
    chk("empty", 64'(bus.Empty), 64'(sbq.size() == 0));
    chk("full",  64'(bus.Full),  64'(sbq.size() == 4));
    chk("w",     64'(bus.w),     64'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      chk("c",     64'(bus.c), 64'(sbq[0].r));
      chk("datac", bus.DataC,  sbq[0].d);
    end else begin
      chk("c",     64'(bus.c), 64'd0);
      chk("datac", bus.DataC,  64'd0);
    end
    chk("dataa", bus.DataA, fwd_model(bus.a, bus.RegDataA));
    chk("datab", bus.DataB, fwd_model(bus.b, bus.RegDataB));
    @(posedge clk);
    if (rst) begin
      sbq.delete();
    end else begin
      if (sbq.size() != 0) void'(sbq.pop_front());
      if (!st) begin
        if (bus.MemValid && bus.MemReg != 5'd31) begin
          e.r = bus.MemReg; e.d = bus.MemData; sbq.push_back(e);
        end
        if (bus.AluValid && bus.AluReg != 5'd31) begin
          e.r = bus.AluReg; e.d = bus.AluData; sbq.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    bus.a = 5'd0; bus.b = 5'd1;
    bus.RegDataA = 64'h99; bus.RegDataB = 64'h5A5A_0000_1111_2222;
    // Reset with live requests: they must be ignored.
    drive(1'b1, 5'd5, 64'hDEAD, 1'b1, 5'd6, 64'hBEEF);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle();
    tick();

    // Single ALU push.
    bus.a = 5'd5;
    drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
    tick();
    idle();
    tick(); tick();

    // Dual push: Mem drains before Alu.
    bus.a = 5'd3; bus.b = 5'd4;
    drive(1'b1, 5'd4, 64'hBB, 1'b1, 5'd3, 64'hAA);
    tick();
    idle();
    tick(); tick(); tick();

    // Fill to 4 with dual pushes, then a stalled dual push, then single pushes at Full.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(10 + 2 * i), 64'h100 + 64'(i), 1'b1, 5'(11 + 2 * i), 64'h200 + 64'(i));
      tick();
    end
    drive(1'b1, 5'd20, 64'h300, 1'b1, 5'd21, 64'h301);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.a = 5'(22 + i);
      drive(1'b1, 5'(22 + i), 64'h400 + 64'(i), 1'b0, 5'd0, 64'd0);
      tick();
    end
    // Mem to XZR plus Alu at Full counts as one request.
    drive(1'b1, 5'd2, 64'h500, 1'b1, 5'd31, 64'h501);
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();

    // Duplicate destinations: youngest forwards, then falls back to the bank.
    bus.a = 5'd7; bus.RegDataA = 64'h99;
    drive(1'b1, 5'd7, 64'h22, 1'b1, 5'd7, 64'h11);
    tick();
    idle();
    tick(); tick(); tick();

    // XZR write is discarded, XZR read is zero.
    bus.a = 5'd31;
    drive(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 64'd0);
    tick();
    idle();
    tick();

    // Reset with three queued entries drops them.
    bus.a = 5'd8;
    drive(1'b1, 5'd8, 64'h600, 1'b1, 5'd9, 64'h601);
    tick();
    drive(1'b1, 5'd8, 64'h602, 1'b1, 5'd12, 64'h603);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    tick(); tick();

    // Randomised traffic over a small register set for forwarding and stall coverage.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(1, 6)),
            {$urandom, $urandom},
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(1, 6)),
            {$urandom, $urandom});
      bus.a = 5'($urandom_range(0, 7));
      bus.b = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(1, 6));
      bus.RegDataA = {$urandom, $urandom};
      bus.RegDataB = {$urandom, $urandom};
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
